// File: rtl/ice_bar_pkg.sv
// Definitions shared by the ice-bar vending FSM and the change dispenser:
// coin codes, change width, dispenser state encoding and the request layout.
package ice_bar_pkg;

  localparam int CHANGE_W = 3;

  localparam logic [1:0] NOTHING = 2'b00;
  localparam logic [1:0] NIS_2   = 2'b10;
  localparam logic [1:0] NIS_5   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BAR   = 3'd2,
    ST_EJECT = 3'd3,
    ST_GAP   = 3'd4,
    ST_FAULT = 3'd5
  } disp_state_e;

  typedef struct packed {
    logic                rls;
    logic [CHANGE_W-1:0] change;
  } req_t;

endpackage

// File: rtl/change_dispenser_req_fifo.sv
// Request queue between the vending FSM and the dispenser FSM. A push while
// full succeeds only if the head is popped in the same cycle.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign wr_d    = wr_q + (AW+1)'(do_push);
  assign rd_d    = rd_q + (AW+1)'(do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage holds data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues {rls, change} requests, pulses the bar actuator and
// feeds the coin hopper one coin at a time. CHANGE_DISPENSER_TALLY_EN adds coin_total.
module change_dispenser #(
  parameter int FIFO_DEPTH  = 4,
  parameter int RLS_PULSE   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rls,
  input  logic [2:0] change,
  input  logic       coin_sense,
  input  logic       fault_clr,
  output logic       bar_drop,
  output logic       coin_eject,
  output logic       busy,
  output logic       fault,
  output logic [2:0] owed,
  output logic       overflow
`ifdef CHANGE_DISPENSER_TALLY_EN
  ,
  output logic [15:0] coin_total
`endif
);
  import ice_bar_pkg::*;

  localparam int BAR_CW = $clog2(RLS_PULSE + 1);
  localparam int TO_CW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(RLS_PULSE - 1);
  localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(TIMEOUT_CYC - 1);

  disp_state_e         state_q, state_d;
  req_t                ent_q, ent_d;
  req_t                push_ent, head;
  logic [CHANGE_W-1:0] owed_q, owed_d;
  logic [BAR_CW-1:0]   bar_cnt_q, bar_cnt_d;
  logic [TO_CW-1:0]    to_cnt_q, to_cnt_d;
  logic                overflow_q, overflow_d;
  logic                push, pop, full, empty;

  assign push_ent = '{rls: rls, change: change};
  assign push     = rls | (change != '0);
  assign pop      = (state_q == ST_IDLE) & ~empty;

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (1 + CHANGE_W)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_ent),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    owed_d     = owed_q;
    bar_cnt_d  = bar_cnt_q;
    to_cnt_d   = to_cnt_q;
    overflow_d = overflow_q | (push & full & ~pop);
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          ent_d   = head;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        owed_d    = ent_q.change;
        bar_cnt_d = '0;
        to_cnt_d  = '0;
        if (ent_q.rls)                state_d = ST_BAR;
        else if (ent_q.change != '0)  state_d = ST_EJECT;
        else                          state_d = ST_IDLE;
      end
      ST_BAR: begin
        to_cnt_d = '0;
        if (bar_cnt_q == BAR_LAST) state_d = (owed_q != '0) ? ST_EJECT : ST_IDLE;
        else                       bar_cnt_d = bar_cnt_q + BAR_CW'(1);
      end
      ST_EJECT: begin
        // A sense on the final allowed cycle still counts as a dispensed coin.
        if (coin_sense) begin
          if (owed_q != '0) owed_d = owed_q - CHANGE_W'(1);
          state_d = ST_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + TO_CW'(1);
        end
      end
      ST_GAP: begin
        to_cnt_d = '0;
        state_d  = (owed_q != '0) ? ST_EJECT : ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          owed_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      owed_q     <= '0;
      bar_cnt_q  <= '0;
      to_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owed_q     <= owed_d;
      bar_cnt_q  <= bar_cnt_d;
      to_cnt_q   <= to_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign bar_drop   = (state_q == ST_BAR);
  assign coin_eject = (state_q == ST_EJECT);
  assign fault      = (state_q == ST_FAULT);
  assign busy       = (state_q != ST_IDLE) | ~empty;
  assign owed       = owed_q;
  assign overflow   = overflow_q;

`ifdef CHANGE_DISPENSER_TALLY_EN
  logic [15:0] tally_q;
  logic        coin_ok;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign coin_ok = (state_q == ST_EJECT) & coin_sense;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        tally_q <= '0;
    else if (coin_ok) tally_q <= sat_inc16(tally_q);
  end

  assign coin_total = tally_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a hopper model answers coin_eject, a monitor
// logs bar pulses and coin ejections, and a transaction model predicts that log.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rls = 1'b0;
  logic [2:0] change = 3'd0;
  logic       coin_sense = 1'b0;
  logic       fault_clr = 1'b0;
  logic       bar_drop, coin_eject, busy, fault, overflow;
  logic [2:0] owed;
`ifdef CHANGE_DISPENSER_TALLY_EN
  logic [15:0] coin_total;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam int NEVER = 0;
  int sense_dly = 2;
  bit sense_kick = 1'b0;
  int ej_cyc = 0;

  int ev_q[$];
  int exp_q[$];
  int bar_run = 0;
  bit ej_prev = 1'b0;

  change_dispenser dut (
    .clk        (clk),
    .nrst       (nrst),
    .rls        (rls),
    .change     (change),
    .coin_sense (coin_sense),
    .fault_clr  (fault_clr),
    .bar_drop   (bar_drop),
    .coin_eject (coin_eject),
    .busy       (busy),
    .fault      (fault),
    .owed       (owed),
    .overflow   (overflow)
`ifdef CHANGE_DISPENSER_TALLY_EN
    ,
    .coin_total (coin_total)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Hopper: answers the sense_dly-th cycle of each eject pulse (or on demand).
  always @(negedge clk) begin
    if (coin_eject) begin
      ej_cyc = ej_cyc + 1;
      coin_sense = ((sense_dly != NEVER) && (ej_cyc == sense_dly)) || sense_kick;
      if (coin_sense) sense_kick = 1'b0;
    end else begin
      ej_cyc = 0;
      coin_sense = 1'b0;
    end
  end

  // Monitor: bar pulse -> 1000+length; eject start -> owed at that moment.
  always @(negedge clk) begin
    if (!nrst) begin
      bar_run = 0;
      ej_prev = 1'b0;
    end else begin
      if (bar_drop) bar_run = bar_run + 1;
      else if (bar_run != 0) begin
        ev_q.push_back(1000 + bar_run);
        bar_run = 0;
      end
      if (coin_eject && !ej_prev) ev_q.push_back(int'(owed));
      ej_prev = coin_eject;
    end
  end

  // Transaction model: a release is one 4-cycle bar pulse, then one coin per
  // unit of change with owed counting down from the full amount.
  function automatic void model_req(input bit r, input int c);
    if (r) exp_q.push_back(1000 + 4);
    for (int k = c; k >= 1; k--) exp_q.push_back(k);
  endfunction

  task automatic push_req(input bit r, input int c);
    rls = r;
    change = 3'(c);
    @(negedge clk);
    rls = 1'b0;
    change = 3'd0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_eject(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (coin_eject) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bar_drop, coin_eject, busy, fault, overflow, owed} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_held: got outputs %b, expected 00000000",
               {bar_drop, coin_eject, busy, fault, overflow, owed});
    end
    nrst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bar_drop, coin_eject, busy, fault, overflow, owed} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_released: got outputs %b, expected 00000000",
               {bar_drop, coin_eject, busy, fault, overflow, owed});
    end
  endtask

  task automatic test_single();
    bit ok;
    bit same;
    clear_log();
    sense_dly = 2;
    rls = 1'b1;
    change = 3'b010;
    @(negedge clk);
    rls = 1'b0;
    change = 3'd0;
    vectors++;
    if (busy !== 1'b1 || bar_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL single_capture: got busy=%b bar_drop=%b, expected busy=1 bar_drop=0", busy, bar_drop);
    end
    @(negedge clk);
    vectors++;
    if (bar_drop !== 1'b0 || owed !== 3'd0) begin
      miscompares++;
      $display("FAIL single_pop: got bar_drop=%b owed=%0d, expected bar_drop=0 owed=0", bar_drop, owed);
    end
    @(negedge clk);
    vectors++;
    if (bar_drop !== 1'b1 || owed !== 3'd2) begin
      miscompares++;
      $display("FAIL single_latch: got bar_drop=%b owed=%0d, expected bar_drop=1 owed=2", bar_drop, owed);
    end
    model_req(1'b1, 2);
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b after 200 cycles, expected 0", busy);
    end
    same = (ev_q.size() == exp_q.size());
    if (same) foreach (ev_q[i]) if (ev_q[i] != exp_q[i]) same = 1'b0;
    vectors++;
    if (!same) begin
      miscompares++;
      $display("FAIL single_events: got %p, expected %p", ev_q, exp_q);
    end
    vectors++;
    if (owed !== 3'd0) begin
      miscompares++;
      $display("FAIL single_owed_end: got %0d, expected 0", owed);
    end
  endtask

  task automatic test_eject_only();
    bit ok;
    bit same;
    clear_log();
    sense_dly = 2;
    push_req(1'b0, 1);
    model_req(1'b0, 1);
    wait_idle(100, ok);
    same = ok && (ev_q.size() == exp_q.size());
    if (same) foreach (ev_q[i]) if (ev_q[i] != exp_q[i]) same = 1'b0;
    vectors++;
    if (!same) begin
      miscompares++;
      $display("FAIL eject_only_events: got %p (idle=%b), expected %p", ev_q, ok, exp_q);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit same;
    int nb, r, c, gap;
    for (int b = 0; b < 12; b++) begin
      clear_log();
      sense_dly = $urandom_range(1, 4);
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        r = $urandom_range(0, 1);
        c = $urandom_range(0, 7);
        fault_clr = ($urandom_range(0, 3) == 0);
        model_req(r[0], c);
        push_req(r[0], c);
        fault_clr = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
      wait_idle(600, ok);
      same = ok && (ev_q.size() == exp_q.size());
      if (same) foreach (ev_q[i]) if (ev_q[i] != exp_q[i]) same = 1'b0;
      vectors++;
      if (!same) begin
        miscompares++;
        $display("FAIL random_burst%0d: got %p (idle=%b), expected %p", b, ev_q, ok, exp_q);
      end
    end
    vectors++;
    if (overflow !== 1'b0 || fault !== 1'b0 || owed !== 3'd0) begin
      miscompares++;
      $display("FAIL random_end: got overflow=%b fault=%b owed=%0d, expected 0 0 0", overflow, fault, owed);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    bit same;
    int r, c;
    clear_log();
    sense_dly = NEVER;
    push_req(1'b0, 1);
    model_req(1'b0, 1);
    wait_eject(10, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL overflow_stall: got coin_eject=%b, expected 1", coin_eject);
    end
    for (int i = 0; i < 5; i++) begin
      r = $urandom_range(0, 1);
      c = $urandom_range(0, 7);
      if (r == 0 && c == 0) c = 1;
      if (i < 4) model_req(r[0], c);
      rls = r[0];
      change = 3'(c);
      fault_clr = (i == 1);
      @(negedge clk);
      fault_clr = 1'b0;
      if (i == 3) begin
        vectors++;
        if (overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL overflow_four: got %b, expected 0", overflow);
        end
      end
    end
    rls = 1'b0;
    change = 3'd0;
    vectors++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_fifth: got overflow=%b busy=%b, expected 1 1", overflow, busy);
    end
    sense_dly = 2;
    sense_kick = 1'b1;
    wait_idle(800, ok);
    same = ok && (ev_q.size() == exp_q.size());
    if (same) foreach (ev_q[i]) if (ev_q[i] != exp_q[i]) same = 1'b0;
    vectors++;
    if (!same) begin
      miscompares++;
      $display("FAIL overflow_order: got %p (idle=%b), expected %p", ev_q, ok, exp_q);
    end
    vectors++;
    if (overflow !== 1'b1 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_sticky: got overflow=%b fault=%b, expected 1 0", overflow, fault);
    end
  endtask

  task automatic test_fault();
    bit ok;
    bit same;
    int n;
    clear_log();
    sense_dly = NEVER;
    push_req(1'b0, 3);
    push_req(1'b0, 1);
    exp_q.push_back(3);
    wait_eject(10, ok);
    n = 0;
    while (coin_eject && n < 40) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (!ok || n != 16) begin
      miscompares++;
      $display("FAIL fault_timeout_len: got %0d eject cycles (seen=%b), expected 16", n, ok);
    end
    vectors++;
    if (fault !== 1'b1 || owed !== 3'd3 || busy !== 1'b1 || coin_eject !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_state: got fault=%b owed=%0d busy=%b eject=%b, expected 1 3 1 0",
               fault, owed, busy, coin_eject);
    end
    sense_dly = 2;
    push_req(1'b1, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (fault !== 1'b1 || owed !== 3'd3 || ev_q.size() != 1) begin
      miscompares++;
      $display("FAIL fault_hold: got fault=%b owed=%0d events=%0d, expected 1 3 1", fault, owed, ev_q.size());
    end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    vectors++;
    if (fault !== 1'b0 || owed !== 3'd0) begin
      miscompares++;
      $display("FAIL fault_clear: got fault=%b owed=%0d, expected 0 0", fault, owed);
    end
    model_req(1'b0, 1);
    model_req(1'b1, 0);
    wait_idle(200, ok);
    same = ok && (ev_q.size() == exp_q.size());
    if (same) foreach (ev_q[i]) if (ev_q[i] != exp_q[i]) same = 1'b0;
    vectors++;
    if (!same) begin
      miscompares++;
      $display("FAIL fault_resume: got %p (idle=%b), expected %p", ev_q, ok, exp_q);
    end
  endtask

  task automatic test_reset_mid_eject();
    bit ok;
    sense_dly = NEVER;
    push_req(1'b0, 3);
    push_req(1'b1, 2);
    wait_eject(10, ok);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    vectors++;
    if (!ok || coin_eject !== 1'b0 || bar_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got eject=%b bar=%b (seen=%b), expected 0 0", coin_eject, bar_drop, ok);
    end
    @(negedge clk);
    nrst = 1'b1;
    sense_dly = 2;
    clear_log();
    vectors++;
    if ({busy, owed, fault, overflow} !== 6'd0) begin
      miscompares++;
      $display("FAIL rst_release: got busy=%b owed=%0d fault=%b overflow=%b, expected all 0",
               busy, owed, fault, overflow);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ev_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_discard: got busy=%b events=%0d, expected 0 0", busy, ev_q.size());
    end
  endtask

`ifdef CHANGE_DISPENSER_TALLY_EN
  task automatic test_tally();
    bit ok;
    vectors++;
    if (coin_total !== 16'd0) begin
      miscompares++;
      $display("FAIL tally_reset: got %0d, expected 0", coin_total);
    end
    sense_dly = 2;
    push_req(1'b0, 4);
    push_req(1'b0, 1);
    wait_idle(200, ok);
    vectors++;
    if (!ok || coin_total !== 16'd5) begin
      miscompares++;
      $display("FAIL tally_count: got %0d (idle=%b), expected 5", coin_total, ok);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_eject_only();
    test_random();
    test_overflow();
    test_fault();
    test_reset_mid_eject();
`ifdef CHANGE_DISPENSER_TALLY_EN
    test_tally();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
